// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: 8N1 host commands ('W' addr data / 'R' addr) become
// single 32-bit bus accesses; results are returned as ACK, NAK or read data.
module uart_dbg_bridge #(
   parameter int unsigned CLK_FREQ = 32'd100_000_000,
   parameter int unsigned BAUD     = 115200,
   parameter int unsigned TIMEOUT  = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int unsigned DIV  = CLK_FREQ / BAUD;
   localparam int          CW   = $clog2(DIV + 1);
   localparam int          TW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

   logic [1:0]    rx_sync_q;
   logic          rx_prev_q;
   logic          rx_s;
   rx_st_t        rx_st_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_sh_q;
   logic          rx_done_q;
   logic          rx_ferr_q;

   assign rx_s = rx_sync_q[1];

   // Synchronizer keeps tracking the line through reset, so a line already low at release is not a start edge
   always_ff @(posedge clk) begin
      rx_sync_q <= {rx_sync_q[0], uart_rx};
      rx_prev_q <= rx_s;
   end

   // RX bit engine: start validation at half bit, then one sample per bit period
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_st_q   <= RX_IDLE;
         rx_cnt_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
         rx_done_q <= 1'b0;
         rx_ferr_q <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         case (rx_st_q)
            RX_IDLE: if (rx_prev_q && !rx_s) begin
               rx_st_q  <= RX_START;
               rx_cnt_q <= '0;
            end
            RX_START: if (rx_cnt_q == HALF) begin
               rx_cnt_q <= '0;
               rx_bit_q <= '0;
               rx_st_q  <= rx_s ? RX_IDLE : RX_DATA;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_DATA: if (rx_cnt_q == LAST) begin
               rx_cnt_q <= '0;
               rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
               rx_bit_q <= rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_STOP: if (rx_cnt_q == LAST) begin
               rx_cnt_q  <= '0;
               rx_done_q <= 1'b1;
               rx_ferr_q <= !rx_s;
               rx_st_q   <= RX_IDLE;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            default: rx_st_q <= RX_IDLE;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   logic [9:0]    tx_sh_q;
   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bit_q;
   logic          tx_busy_q;
   logic          tx_last;
   logic          tx_free;
   logic          tx_ld;
   logic [7:0]    tx_byte;

   // A new byte may load in the final stop-bit cycle, giving gapless back-to-back frames
   assign tx_last = tx_busy_q && (tx_cnt_q == LAST) && (tx_bit_q == 4'd9);
   assign tx_free = !tx_busy_q || tx_last;
   assign uart_tx = tx_busy_q ? tx_sh_q[0] : 1'b1;

   // TX shifter: start, 8 data LSB first, stop
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tx_busy_q <= 1'b0;
         tx_sh_q   <= '1;
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
      end else if (tx_ld) begin
         tx_sh_q   <= {1'b1, tx_byte, 1'b0};
         tx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         tx_busy_q <= 1'b1;
      end else if (tx_busy_q) begin
         if (tx_cnt_q == LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
            else begin
               tx_bit_q <= tx_bit_q + 4'd1;
               tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
            end
         end else tx_cnt_q <= tx_cnt_q + 1'b1;
      end
   end

   // ---------------- command FSM ----------------
   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RESP} st_t;

   st_t           st_q, st_d;
   logic          is_wr_q;
   logic [1:0]    bcnt_q;
   logic [31:0]   addr_q, wdata_q, resp_q;
   logic [3:0]    wstrb_q;
   logic          mem_valid_q, mem_valid_d;
   logic [TW-1:0] tcnt_q;
   logic [2:0]    rcnt_q;
   logic          rx_good, rx_bad, is_cmd, tout, bus_end;
   logic          resp_ld;
   logic [31:0]   resp_val;
   logic [2:0]    resp_n;

   assign rx_good = rx_done_q && !rx_ferr_q;
   assign rx_bad  = rx_done_q && rx_ferr_q;
   assign is_cmd  = (rx_sh_q == CMD_W) || (rx_sh_q == CMD_R);
   assign tout    = mem_valid_q && !mem_ready && (tcnt_q == TLAST);
   assign bus_end = mem_valid_q && (mem_ready || tout);

   assign mem_valid = mem_valid_q;
   assign mem_instr = 1'b0;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;
   assign busy      = (st_q != ST_IDLE);

   // FSM state register
   always_ff @(posedge clk) begin
      if (!resetn) st_q <= ST_IDLE;
      else         st_q <= st_d;
   end

   // FSM next state
   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: if (rx_good) st_d = is_cmd ? ST_ADDR : ST_RESP;
         ST_ADDR: if (rx_bad) st_d = ST_RESP;
                  else if (rx_good && bcnt_q == 2'd3) st_d = is_wr_q ? ST_DATA : ST_BUS;
         ST_DATA: if (rx_bad) st_d = ST_RESP;
                  else if (rx_good && bcnt_q == 2'd3) st_d = ST_BUS;
         ST_BUS:  if (bus_end) st_d = ST_RESP;
         ST_RESP: if (tx_free && rcnt_q == 3'd0) st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
   end

   // FSM outputs: bus request, response selection, TX byte loading
   always_comb begin
      mem_valid_d = 1'b0;
      resp_ld     = 1'b0;
      resp_val    = {24'h0, NAK};
      resp_n      = 3'd1;
      tx_ld       = 1'b0;
      tx_byte     = resp_q[7:0];
      case (st_q)
         ST_IDLE: resp_ld = rx_good && !is_cmd;
         ST_ADDR, ST_DATA: resp_ld = rx_bad;
         ST_BUS: begin
            mem_valid_d = !bus_end;
            if (bus_end) begin
               resp_ld = 1'b1;
               if (!tout) begin
                  if (is_wr_q) resp_val = {24'h0, ACK};
                  else begin
                     resp_val = mem_rdata;
                     resp_n   = 3'd4;
                  end
               end
            end
         end
         ST_RESP: tx_ld = tx_free && (rcnt_q != 3'd0);
         default: ;
      endcase
   end

   // Datapath: operand assembly (little-endian), bus handshake, timeout, response queue
   always_ff @(posedge clk) begin
      if (!resetn) begin
         is_wr_q     <= 1'b0;
         bcnt_q      <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         mem_valid_q <= 1'b0;
         tcnt_q      <= '0;
         resp_q      <= '0;
         rcnt_q      <= '0;
      end else begin
         mem_valid_q <= mem_valid_d;
         tcnt_q      <= (mem_valid_q && mem_valid_d) ? tcnt_q + 1'b1 : '0;
         if (st_q == ST_IDLE && rx_good && is_cmd) begin
            is_wr_q <= (rx_sh_q == CMD_W);
            wstrb_q <= (rx_sh_q == CMD_W) ? 4'hF : 4'h0;
            bcnt_q  <= '0;
         end
         if (st_q == ST_ADDR && rx_good) begin
            addr_q <= {rx_sh_q, addr_q[31:8]};
            bcnt_q <= bcnt_q + 2'd1;
         end
         if (st_q == ST_DATA && rx_good) begin
            wdata_q <= {rx_sh_q, wdata_q[31:8]};
            bcnt_q  <= bcnt_q + 2'd1;
         end
         if (resp_ld) begin
            resp_q <= resp_val;
            rcnt_q <= resp_n;
         end else if (tx_ld) begin
            resp_q <= {8'h0, resp_q[31:8]};
            rcnt_q <= rcnt_q - 3'd1;
         end
      end
   end

endmodule

// File: doc/uart_dbg_bridge.md
UART_DBG_BRIDGE -- requirements
Module: uart_dbg_bridge

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 32'd100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; DIV = CLK_FREQ/BAUD clocks per bit, minimum 2.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum clocks a bus access may wait for mem_ready.
REQ-004 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port uart_rx, input, 1, serial command line from host, idle high.
REQ-007 SHALL have port uart_tx, output, 1, serial response line to host, idle high.
REQ-008 SHALL have ports mem_valid out 1, mem_instr out 1, mem_ready in 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4, mem_rdata in 32, forming a bus-initiator port.
REQ-009 SHALL have port busy, output, 1, high from the first command byte accepted until the last response stop bit ends.

Function
REQ-010 Serial format SHALL be fixed 8N1, LSB first, no parity, no flow control.
REQ-011 RX SHALL pass uart_rx through a 2-flop synchronizer, detect a falling edge in RX idle, re-sample at DIV/2 and abort silently if high (glitch).
REQ-012 RX SHALL sample data bits every DIV clocks after the start mid-point; stop bit low SHALL flag a frame error.
REQ-013 Command 0x57 ('W') SHALL be followed by 4 address bytes then 4 data bytes, each little-endian.
REQ-014 Command 0x52 ('R') SHALL be followed by 4 address bytes, little-endian.
REQ-015 Any other command byte SHALL produce one 0x15 (NAK) response, then return to IDLE.
REQ-016 FSM states: IDLE, ADDR (4 bytes), DATA (4 bytes, write only), BUS, RESP; IDLE->ADDR on 'W'/'R'; ADDR->DATA (W) or BUS (R) after 4th byte; DATA->BUS after 4th byte; BUS->RESP on completion or timeout; RESP->IDLE after last response byte's stop bit.
REQ-017 A frame error in ADDR or DATA SHALL abort the command, send 0x15, return to IDLE; a frame error in IDLE SHALL discard the byte, no response.
REQ-018 Bytes received in BUS or RESP SHALL be discarded.
REQ-019 In BUS, mem_valid SHALL rise the cycle after entry with mem_addr, mem_wdata, mem_wstrb stable while high; mem_instr SHALL be 0 always.
REQ-020 mem_wstrb SHALL be 4'hF for writes, 4'h0 for reads; mem_addr SHALL be used as received, no alignment check.
REQ-021 Transfer SHALL complete in the cycle mem_ready=1 while mem_valid=1; mem_rdata SHALL be captured that cycle; mem_valid SHALL be 0 the next cycle.
REQ-022 If mem_ready is not seen within TIMEOUT cycles of mem_valid rising, mem_valid SHALL drop and response SHALL be 0x15.
REQ-023 Write success response SHALL be single byte 0x06 (ACK).
REQ-024 Read success response SHALL be 4 bytes of captured mem_rdata, little-endian.
REQ-025 TX SHALL emit start, 8 data, 1 stop, each DIV clocks, back-to-back response bytes with no idle gap.
REQ-026 busy SHALL fall in the same cycle the FSM re-enters IDLE.

Reset
REQ-027 During resetn=0: uart_tx=1, mem_valid=0, mem_instr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, FSM=IDLE, RX idle, timeout counter 0.
REQ-028 Reset mid-frame or mid-bus-access SHALL abandon the operation with no response; first edge after release SHALL be treated as a new start bit only if uart_rx falls.

Verification
REQ-029 Host sends 57 10 10 00 80 41 00 00 00, responder ready 1 cycle after valid -> one write, addr 0x80001010, wdata 0x00000041, wstrb F; uart_tx returns 0x06.
REQ-030 Host sends 52 08 10 00 80, responder returns mem_rdata 0x00000043 -> wstrb 0; uart_tx returns 43 00 00 00.
REQ-031 Host sends 0xA5 -> no bus access; uart_tx returns 0x15; busy low after stop bit.
REQ-032 Read to unresponsive address, TIMEOUT=16 -> mem_valid high exactly 16 cycles then low; uart_tx returns 0x15.
REQ-033 Byte with stop bit held low after 57 and 2 address bytes -> no bus access, 0x15 returned, next valid command executes normally.
REQ-034 resetn pulsed low during DATA phase of a write -> no bus access, no response, uart_tx=1, subsequent 'R' command completes correctly.
